// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with an optional hardwired zero register,
// write-to-read forwarding and a per-register busy scoreboard.
module regfile_2w2r #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [AW-1:0]    Ra,
    input  logic [AW-1:0]    Rb,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    input  logic             We0,
    input  logic [AW-1:0]    Wr0,
    input  logic [WIDTH-1:0] D0,
    input  logic             We1,
    input  logic [AW-1:0]    Wr1,
    input  logic [WIDTH-1:0] D1,
    input  logic             Bs,
    input  logic [AW-1:0]    Bsr,
    output logic             BusyA,
    output logic             BusyB
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_we0_eff;
    logic             w_we1_eff;

    function automatic logic is_zero_addr(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == {AW{1'b0}});
    endfunction

    // Resolve one read port: reset forces 0, then zero register, then forwarding, then storage.
    function automatic logic [WIDTH-1:0] read_port(
        input logic             clr,
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             we0,
        input logic [AW-1:0]    wr0,
        input logic [WIDTH-1:0] d0,
        input logic             we1,
        input logic [AW-1:0]    wr1,
        input logic [WIDTH-1:0] d1
    );
        logic [WIDTH-1:0] q;
        if (clr) begin
            q = {WIDTH{1'b0}};
        end else if (is_zero_addr(addr)) begin
            q = {WIDTH{1'b0}};
        end else if ((BYPASS != 0) && we1 && (wr1 == addr)) begin
            q = d1;
        end else if ((BYPASS != 0) && we0 && (wr0 == addr)) begin
            q = d0;
        end else begin
            q = stored;
        end
        return q;
    endfunction

    // Effective write enables: port 1 shadows port 0 on the same address; address 0 may be read-only.
    always_comb begin
        w_we1_eff = We1 && !is_zero_addr(Wr1);
        w_we0_eff = We0 && !is_zero_addr(Wr0) && !(We1 && (Wr1 == Wr0));
    end

    // Register storage.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_we0_eff) begin
                r_mem[Wr0] <= D0;
            end
            if (w_we1_eff) begin
                r_mem[Wr1] <= D1;
            end
        end
    end

    // Scoreboard next state: a new producer (set) outranks a completing write (clear).
    always_comb begin
        w_busy_nxt = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_nxt[i] = ((Bs && (Bsr == AW'(i)))
                            || (r_busy[i] && !((We0 && (Wr0 == AW'(i))) || (We1 && (Wr1 == AW'(i))))))
                            && !is_zero_addr(AW'(i));
        end
    end

    // Scoreboard state.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_busy <= {DEPTH{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports and busy lookup; busy reflects registered state only.
    always_comb begin
        Qa    = read_port(Clr, Ra, r_mem[Ra], We0, Wr0, D0, We1, Wr1, D1);
        Qb    = read_port(Clr, Rb, r_mem[Rb], We0, Wr0, D0, We1, Wr1, D1);
        BusyA = !Clr && r_busy[Ra];
        BusyB = !Clr && r_busy[Rb];
    end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: a forwarding instance and a non-forwarding
// instance share all inputs.
module tb_regfile_2w2r;

    logic        Clk;
    logic        Clr;
    logic [4:0]  Ra, Rb, Wr0, Wr1, Bsr;
    logic [31:0] D0, D1;
    logic        We0, We1, Bs;
    logic [31:0] Qa, Qb, Qa_nb, Qb_nb;
    logic        BusyA, BusyB, BusyA_nb, BusyB_nb;

    int n_checks = 0;
    int n_errors = 0;

    regfile_2w2r #(.WIDTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .Clk(Clk), .Clr(Clr), .Ra(Ra), .Rb(Rb), .Qa(Qa), .Qb(Qb),
        .We0(We0), .Wr0(Wr0), .D0(D0), .We1(We1), .Wr1(Wr1), .D1(D1),
        .Bs(Bs), .Bsr(Bsr), .BusyA(BusyA), .BusyB(BusyB)
    );

    regfile_2w2r #(.WIDTH(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .Clk(Clk), .Clr(Clr), .Ra(Ra), .Rb(Rb), .Qa(Qa_nb), .Qb(Qb_nb),
        .We0(We0), .Wr0(Wr0), .D0(D0), .We1(We1), .Wr1(Wr1), .D1(D1),
        .Bs(Bs), .Bsr(Bsr), .BusyA(BusyA_nb), .BusyB(BusyB_nb)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        We0 = 1'b0; We1 = 1'b0; Bs = 1'b0;
        Wr0 = 5'd0; Wr1 = 5'd0; Bsr = 5'd0;
        D0 = 32'd0; D1 = 32'd0;
    endtask

    initial begin
        Clr = 1'b1; Ra = 5'd0; Rb = 5'd0;
        idle();
        #12;
        Ra = 5'd5; Rb = 5'd31;
        #1;
        check("reset_qa", Qa, 32'd0);
        check("reset_qb", Qb, 32'd0);
        check("reset_busya", {31'd0, BusyA}, 32'd0);
        Clr = 1'b0;
        edge_step();

        // fill registers 1..31
        for (int i = 1; i < 32; i++) begin
            We0 = 1'b1; Wr0 = 5'(i); D0 = pat(i);
            edge_step();
        end
        idle();
        Ra = 5'd3; Rb = 5'd31;
        #1;
        check("fill_r3", Qa, pat(3));
        check("fill_r31", Qb, pat(31));

        // same-cycle forwarding vs. no forwarding
        We0 = 1'b1; Wr0 = 5'd5; D0 = 32'hDEADBEEF; Ra = 5'd5;
        #1;
        check("bypass_same_cycle", Qa, 32'hDEADBEEF);
        check("nobypass_old", Qa_nb, pat(5));
        edge_step();
        idle();
        #1;
        check("nobypass_after_edge", Qa_nb, 32'hDEADBEEF);

        // both ports to the same address: port 1 wins
        We0 = 1'b1; Wr0 = 5'd7; D0 = 32'h1111;
        We1 = 1'b1; Wr1 = 5'd7; D1 = 32'h2222; Rb = 5'd7;
        #1;
        check("same_addr_bypass", Qb, 32'h2222);
        edge_step();
        idle();
        #1;
        check("same_addr_stored", Qb, 32'h2222);
        check("same_addr_stored_nb", Qb_nb, 32'h2222);

        // both ports to different addresses both land
        We0 = 1'b1; Wr0 = 5'd20; D0 = 32'h0000_AAAA;
        We1 = 1'b1; Wr1 = 5'd21; D1 = 32'h0000_BBBB;
        edge_step();
        idle();
        Ra = 5'd20; Rb = 5'd21;
        #1;
        check("dual_write_p0", Qa_nb, 32'h0000_AAAA);
        check("dual_write_p1", Qb_nb, 32'h0000_BBBB);

        // register 0 is hardwired
        We1 = 1'b1; Wr1 = 5'd0; D1 = 32'hFFFF_FFFF; Bs = 1'b1; Bsr = 5'd0; Ra = 5'd0;
        #1;
        check("zero_before_q", Qa, 32'd0);
        check("zero_before_busy", {31'd0, BusyA}, 32'd0);
        edge_step();
        idle();
        #1;
        check("zero_after_q", Qa, 32'd0);
        check("zero_after_busy", {31'd0, BusyA}, 32'd0);

        // busy set then cleared by a port-0 write
        Bs = 1'b1; Bsr = 5'd9; Ra = 5'd9;
        #1;
        check("busy_before_set", {31'd0, BusyA}, 32'd0);
        edge_step();
        idle();
        #1;
        check("busy_set", {31'd0, BusyA}, 32'd1);
        We0 = 1'b1; Wr0 = 5'd9; D0 = 32'h0000_0099;
        #1;
        check("busy_clear_not_bypassed", {31'd0, BusyA}, 32'd1);
        edge_step();
        idle();
        #1;
        check("busy_cleared_p0", {31'd0, BusyA}, 32'd0);

        // busy cleared by a port-1 write
        Bs = 1'b1; Bsr = 5'd14; Rb = 5'd14;
        edge_step();
        idle();
        #1;
        check("busy_set_14", {31'd0, BusyB}, 32'd1);
        We1 = 1'b1; Wr1 = 5'd14; D1 = 32'h0000_0014;
        edge_step();
        idle();
        #1;
        check("busy_cleared_p1", {31'd0, BusyB}, 32'd0);

        // set and clear on the same edge: set wins, data is written
        Bs = 1'b1; Bsr = 5'd12; We1 = 1'b1; Wr1 = 5'd12; D1 = 32'h0000_005A;
        edge_step();
        idle();
        Ra = 5'd12;
        #1;
        check("set_wins_data", Qa_nb, 32'h0000_005A);
        check("set_wins_busy", {31'd0, BusyA}, 32'd1);

        // mid-cycle clear wipes data and busy without waiting for an edge
        Ra = 5'd12; Rb = 5'd31;
        @(negedge Clk);
        Clr = 1'b1;
        #1;
        check("clr_qa", Qa, 32'd0);
        check("clr_qb", Qb, 32'd0);
        check("clr_busya", {31'd0, BusyA}, 32'd0);
        check("clr_busyb_nb", {31'd0, BusyB_nb}, 32'd0);
        We0 = 1'b1; Wr0 = 5'd3; D0 = 32'h3333_3333; Bs = 1'b1; Bsr = 5'd3; Ra = 5'd3;
        #1;
        check("clr_bypass_blocked", Qa, 32'd0);
        edge_step();
        idle();
        Clr = 1'b0;
        #1;
        check("clr_write_ignored", Qa, 32'd0);
        check("clr_busy_ignored", {31'd0, BusyA}, 32'd0);

        // normal operation resumes on the first edge after release
        We0 = 1'b1; Wr0 = 5'd3; D0 = 32'h0000_0303;
        edge_step();
        idle();
        #1;
        check("post_clr_write", Qa_nb, 32'h0000_0303);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
